// File: rtl/rv_lsu.sv
// Load/store unit: issues one request/grant/response memory op per accepted transaction and formats register write-back.
// Optional `RV_LSU_MISALIGN_EN: abort misaligned half/word accesses without touching memory.
module rv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        is_store;
  logic        is_unsigned;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic [4:0]  rd;

  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic        misalign;
  logic        timed_out;
  logic        finish;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be_fmt    = 4'b0001 << req_addr_i[1:0];
        wdata_fmt = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {req_addr_i[1], 1'b0};
        wdata_fmt = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef RV_LSU_MISALIGN_EN
  assign misalign = (req_size_i == 2'b01) ? req_addr_i[0]
                                          : (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Response has priority over the timeout on the last WAIT cycle.
  assign timed_out = (state == WAIT) && !mem_rvalid_i && (cnt == 8'(TIMEOUT - 1));
  assign finish    = ((state == REQ) && mem_gnt_i && mem_rvalid_i) ||
                     ((state == WAIT) && (mem_rvalid_i || timed_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_store    <= 1'b0;
      is_unsigned <= 1'b0;
      size        <= '0;
      lane        <= '0;
      rd          <= '0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      wb_en_o     <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      misalign_o <= 1'b0;
      wb_en_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            is_store    <= req_is_store_i;
            is_unsigned <= req_unsigned_i;
            size        <= req_size_i;
            lane        <= req_addr_i[1:0];
            rd          <= req_rd_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (misalign) begin
              state      <= RESP;
              done_o     <= 1'b1;
              err_o      <= 1'b1;
              misalign_o <= 1'b1;
            end else begin
              state       <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_is_store_i;
              mem_addr_o  <= {req_addr_i[31:2], 2'b00};
              mem_be_o    <= be_fmt;
              mem_wdata_o <= wdata_fmt;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (!mem_rvalid_i) begin
              state <= WAIT;
              cnt   <= '0;
            end
          end
        end
        WAIT: begin
          if (!mem_rvalid_i && !timed_out) cnt <= cnt + 8'd1;
        end
        RESP: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        state  <= RESP;
        done_o <= 1'b1;
        if (timed_out) begin
          err_o <= 1'b1;
        end else if (!is_store && (rd != 5'd0)) begin
          wb_en_o   <= 1'b1;
          wb_rd_o   <= rd;
          wb_data_o <= load_ext(mem_rdata_i, size, lane, is_unsigned);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: directed plan steps plus randomized ops against an arithmetic reference model.
module tb_rv_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_en, done, err, misalign, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .wb_en_o(wb_en), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .done_o(done), .err_o(err), .misalign_o(misalign), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, ".ready"}, req_ready, 1'b1);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".mem_req"}, mem_req, 1'b0);
    chk1({tag, ".done"}, done, 1'b0);
    chk1({tag, ".wb_en"}, wb_en, 1'b0);
    chk1({tag, ".err"}, err, 1'b0);
  endtask

  // gd: cycles with gnt low; rdl: 0 = rvalid with gnt, k = rvalid in k-th cycle after gnt.
  task automatic do_op(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] d, input logic [4:0] rd,
                       input int gd, input int rdl, input logic [31:0] rdata);
    int          off, lsh, waits;
    logic [31:0] ebe, ewd, eld;
    logic        mis, eerr, ewb;
    off = int'(addr[1:0]);
    if (sz == 2'b00) begin
      ebe = 32'(1 << off);
      ewd = {24'b0, d[7:0]} * 32'h0101_0101;
      eld = (rdata >> (8 * off)) & 32'hFF;
      if (!uns && eld >= 32'd128) eld = eld - 32'd256;
    end else if (sz == 2'b01) begin
      lsh = off - (off % 2);
      ebe = 32'(3 << lsh);
      ewd = {16'b0, d[15:0]} * 32'h0001_0001;
      eld = (rdata >> (8 * lsh)) & 32'hFFFF;
      if (!uns && eld >= 32'd32768) eld = eld - 32'd65536;
    end else begin
      ebe = 32'hF;
      ewd = d;
      eld = rdata;
    end
    mis = 1'b0;
`ifdef RV_LSU_MISALIGN_EN
    mis = (sz == 2'b01 && off % 2 == 1) || (sz >= 2'd2 && off != 0);
`endif
    chk1({tag, ".ready_pre"}, req_ready, 1'b1);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = d; req_rd = rd;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_is_store = 1'($urandom);
    chk1({tag, ".ready_busy"}, req_ready, 1'b0);
    chk1({tag, ".busy"}, busy, 1'b1);
    if (mis) begin
      chk1({tag, ".mis_mem_req"}, mem_req, 1'b0);
      chk1({tag, ".mis_done"}, done, 1'b1);
      chk1({tag, ".mis_err"}, err, 1'b1);
      chk1({tag, ".mis_flag"}, misalign, 1'b1);
      chk1({tag, ".mis_wb_en"}, wb_en, 1'b0);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        chk1({tag, ".mem_req"}, mem_req, 1'b1);
        chk({tag, ".mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".mem_be"}, {28'b0, mem_be}, ebe);
        chk({tag, ".mem_wdata"}, mem_wdata, ewd);
        chk1({tag, ".mem_we"}, mem_we, st);
        chk1({tag, ".req_done"}, done, 1'b0);
        mem_gnt    = (c == gd);
        mem_rvalid = (c == gd) ? (rdl == 0) : 1'($urandom);
        mem_rdata  = (c == gd) ? rdata : $urandom;
        step();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      waits = (rdl <= TO) ? rdl : TO;
      for (int k = 1; k <= waits; k++) begin
        chk1({tag, ".wait_mem_req"}, mem_req, 1'b0);
        chk1({tag, ".wait_busy"}, busy, 1'b1);
        chk1({tag, ".wait_done"}, done, 1'b0);
        mem_rvalid = (k == rdl);
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
      end
      eerr = (rdl > TO);
      ewb  = !st && !eerr && (rd != 5'd0);
      chk1({tag, ".done"}, done, 1'b1);
      chk1({tag, ".err"}, err, eerr);
      chk1({tag, ".misalign"}, misalign, 1'b0);
      chk1({tag, ".wb_en"}, wb_en, ewb);
      if (ewb) begin
        chk({tag, ".wb_rd"}, {27'b0, wb_rd}, {27'b0, rd});
        chk({tag, ".wb_data"}, wb_data, eld);
      end
    end
    step();
    chk_quiet({tag, ".after"});
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    chk_quiet("reset");
    chk1("reset.misalign", misalign, 1'b0);
    chk("reset.wb_data", wb_data, 32'h0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // A response while idle must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    chk_quiet("idle_rvalid");

    do_op("st_word",  1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 0, 1, 32'h0);
    do_op("lb_s",     1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,         5'd5, 0, 1, 32'h80FF_1234);
    do_op("lbu",      1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,         5'd5, 0, 1, 32'h80FF_1234);
    do_op("st_half",  1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_ABCD, 5'd0, 4, 1, 32'h0);
    do_op("lw_rd0",   1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0,         5'd0, 0, 0, 32'hCAFE_F00D);
    do_op("lw_zw",    1'b0, 2'b11, 1'b0, 32'h0000_0084, 32'h0,         5'd9, 0, 0, 32'hCAFE_F00D);
    do_op("lw_tmo",   1'b0, 2'b10, 1'b0, 32'h0000_0088, 32'h0,         5'd7, 1, TO + 2, 32'h1);
    do_op("lw_edge",  1'b0, 2'b10, 1'b0, 32'h0000_008C, 32'h0,         5'd7, 0, TO, 32'h5555_AAAA);
    do_op("lh_s",     1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         5'd8, 2, 2, 32'h9ABC_1234);
    do_op("lw_mis",   1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,         5'd4, 0, 1, 32'h0BAD_0001);

    // Reset while waiting for a response: nothing may complete afterwards.
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0300; req_rd = 5'd7;
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk1("rst_mid.in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid.async");
    chk("rst_mid.wb_data", wb_data, 32'h0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    chk_quiet("rst_mid.late_rvalid");
    step();
    chk_quiet("rst_mid.settle");
    do_op("post_rst", 1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0, 5'd6, 0, 1, 32'h0000_F100);

    for (int i = 0; i < 40; i++) begin
      do_op("rnd", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 2)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
